// File: rtl/pipelined_adder_pkg.sv
// Shared types for the chunked pipelined adder: the per-stage register record
// and the helper that splits the operand width into equal chunks.
package pipelined_adder_pkg;

    localparam int MAX_WIDTH = 64;

    // Fields are sized for the widest legal operand; narrower instances use the low bits.
    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] res;
        logic                 carry;
        logic [MAX_WIDTH-1:0] pend_a;
        logic [MAX_WIDTH-1:0] pend_b;
        logic                 msb_cin;
    } stage_t;

    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : 1;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Ripple-carry adder for one pipeline chunk; also exposes the carry into its MSB
// so the last stage can derive signed overflow.
module adder_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] sum_o,
    output logic         c_o,
    output logic         msb_c_o
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        logic ci_bit;
        logic co_bit;
        if (gi == 0) begin : g_lsb
            assign ci_bit = c_i;
        end else begin : g_upper
            assign ci_bit = g_bit[gi-1].co_bit;
        end
        assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ ci_bit;
        assign co_bit    = (a_i[gi] & b_i[gi]) | (ci_bit & (a_i[gi] ^ b_i[gi]));
    end

    assign c_o     = g_bit[W-1].co_bit;
    assign msb_c_o = g_bit[W-1].ci_bit;

endmodule

// File: rtl/pipelined_adder.sv
// Valid/ready pipelined adder/subtractor: each stage adds one CHUNK of the operands
// and passes the carry, remaining operand bits and partial result to the next stage.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   Sum,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0 || WIDTH > MAX_WIDTH)
    begin : g_bad_params
        $fatal(1, "pipelined_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
    end

    stage_t stage_q [STAGES];
    stage_t stage_d [STAGES];
    stage_t cap_entry;
    logic   adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = stage_q[STAGES-1].valid;
    assign Sum       = {stage_q[STAGES-1].carry, WIDTH'(stage_q[STAGES-1].res)};
    assign ovf       = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].msb_cin;

    // Subtraction is A + ~B + 1, so the inversion happens once at capture.
    always_comb begin
        cap_entry        = '0;
        cap_entry.valid  = in_valid;
        cap_entry.carry  = sub | cin;
        cap_entry.pend_a = MAX_WIDTH'(A);
        cap_entry.pend_b = MAX_WIDTH'(sub ? ~B : B);
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        stage_t           src;
        stage_t           nxt;
        logic [CHUNK-1:0] a_chunk;
        logic [CHUNK-1:0] b_chunk;
        logic [CHUNK-1:0] sum_chunk;
        logic             chunk_co;
        logic             chunk_msb_ci;

        if (gi == 0) begin : g_first
            assign src = cap_entry;
        end else begin : g_rest
            assign src = stage_q[gi-1];
        end

        assign a_chunk = src.pend_a[CHUNK-1:0];
        assign b_chunk = src.pend_b[CHUNK-1:0];

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a_i     (a_chunk),
            .b_i     (b_chunk),
            .c_i     (src.carry),
            .sum_o   (sum_chunk),
            .c_o     (chunk_co),
            .msb_c_o (chunk_msb_ci)
        );

        always_comb begin
            nxt         = src;
            nxt.res     = src.res | (MAX_WIDTH'(sum_chunk) << (gi * CHUNK));
            nxt.carry   = chunk_co;
            nxt.pend_a  = src.pend_a >> CHUNK;
            nxt.pend_b  = src.pend_b >> CHUNK;
            nxt.msb_cin = chunk_msb_ci;
        end

        assign stage_d[gi] = adv ? nxt : stage_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed corner
// cases, stall and reset scenarios, then random traffic against a queue model.
module tb_pipelined_adder;

    localparam int W    = 16;
    localparam int SMAX = 2**(W-1) - 1;
    localparam int SMIN = -(2**(W-1));

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   Sum;
    logic         ovf;

    pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W:0] sum;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    bit   verbose  = 1'b1;

    // Arithmetic reference: unsigned value for Sum, signed range test for ovf.
    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic s);
        exp_t e;
        int   u;
        int   sr;
        if (s) begin
            e.sum = {a >= b, W'(a - b)};
            sr    = int'($signed(a)) - int'($signed(b));
        end else begin
            u     = int'(a) + int'(b) + int'(c);
            e.sum = (W+1)'(u);
            sr    = int'($signed(a)) + int'($signed(b)) + int'(c);
        end
        e.ovf = (sr > SMAX) || (sr < SMIN);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: drive at the falling edge, sample 1ns later, score transfers of the next rising edge.
    task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s, input logic ordy, input logic r);
        exp_t e;
        logic fin;
        logic fout;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        A         = a;
        B         = b;
        cin       = c;
        sub       = s;
        out_ready = ordy;
        #1;
        fin  = in_valid && in_ready;
        fout = out_valid && out_ready;
        if (!r) begin
            if (fout) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    n_out++;
                    if (verbose)
                        $display("out beat %0d: Sum=%05h ovf=%0b (model %05h/%0b)", n_out, Sum, ovf, e.sum, e.ovf);
                    check("result_sum", Sum, e.sum);
                    check("result_ovf", ovf, e.ovf);
                end
            end
            if (fin) exp_q.push_back(ref_model(a, b, c, s));
        end
    endtask

    task automatic idle(input logic ordy);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic latency_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic s, input logic [W:0] exp_sum, input logic exp_ovf);
        int lat;
        lat = -1;
        drive_cycle(1'b1, a, b, c, s, 1'b1, 1'b0);
        check({tag, "_accept"}, in_ready, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            idle(1'b1);
            if (out_valid) begin
                lat = i;
                check({tag, "_sum"}, Sum, exp_sum);
                check({tag, "_ovf"}, ovf, exp_ovf);
                break;
            end
        end
        check({tag, "_latency"}, lat, 4);
    endtask

    initial begin
        int           issued;
        int           accepted;
        int           stale;
        logic         ordy;
        logic         v;
        logic [W:0]   held;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        held = '0;

        // Reset state
        drive_cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_sum", Sum, '0);
        check("reset_ovf", ovf, 1'b0);
        idle(1'b1);
        check("reset_inputs_discarded", out_valid, 1'b0);

        // Directed arithmetic corners with latency measurement
        latency_beat("add_basic",       16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0);
        latency_beat("carry_ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
        latency_beat("signed_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
        latency_beat("sub_borrow",      16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0);
        latency_beat("sub_ovf",         16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1);
        latency_beat("cin_ripple",      16'hFFFF, 16'h0000, 1'b1, 1'b0, 17'h10000, 1'b0);
        latency_beat("sub_ignores_cin", 16'h0009, 16'h0003, 1'b1, 1'b1, 17'h10006, 1'b0);

        // Eight back-to-back beats with a three-cycle downstream stall
        issued = 0;
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
        for (int cyc = 0; cyc < 40 && (issued < 8 || exp_q.size() > 0); cyc++) begin
            ordy = !(cyc >= 5 && cyc <= 7);
            drive_cycle(issued < 8, ra, rb, rc, rs, ordy, 1'b0);
            if (cyc >= 5 && cyc <= 7) begin
                check("stall_in_ready", in_ready, 1'b0);
                check("stall_out_valid", out_valid, 1'b1);
                if (cyc == 5) held = Sum;
                else check("stall_sum_held", Sum, held);
            end else if (cyc == 4 || cyc == 8) begin
                check("flow_in_ready", in_ready, 1'b1);
            end
            if (in_valid && in_ready) begin
                issued++;
                ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            end
        end
        check("stall_beats_issued", issued, 8);
        check("stall_drained", exp_q.size(), 0);

        // Reset with three beats in flight and a fourth offered during reset
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.delete();
        idle(1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_sum", Sum, '0);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            if (out_valid) stale++;
        end
        check("midrst_no_stale", stale, 0);
        latency_beat("post_reset", 16'hABCD, 16'h1111, 1'b1, 1'b0, 17'h0BCDF, 1'b0);

        // Random traffic with random backpressure
        verbose  = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 60000 && accepted < 10000; cyc++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            ra   = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            drive_cycle(v, ra, rb, rc, rs, ordy, 1'b0);
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (in_valid && in_ready) accepted++;
        end
        check("random_accepted", accepted, 10000);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
        check("random_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
